// File: rtl/symbol_histogram_x4_if.sv
// symbol_histogram_x4_if: symbol input and four-entry group output bundle of the histogram block
interface symbol_histogram_x4_if #(parameter int DSIZE = 18, parameter int OFFSET = 8);
    logic              in_valid;
    logic              in_ready;
    logic [OFFSET-1:0] in_sym;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DSIZE-1:0]  out_a0;
    logic [DSIZE-1:0]  out_a1;
    logic [DSIZE-1:0]  out_a2;
    logic [DSIZE-1:0]  out_a3;
    logic [3:0]        out_mask;
    logic              out_last;
    modport master (
        output in_valid, in_sym, in_last, out_ready,
        input  in_ready, out_valid, out_a0, out_a1, out_a2, out_a3, out_mask, out_last
    );
    modport slave (
        input  in_valid, in_sym, in_last, out_ready,
        output in_ready, out_valid, out_a0, out_a1, out_a2, out_a3, out_mask, out_last
    );
endinterface

// File: rtl/symbol_histogram_x4.sv
// symbol_histogram_x4: per-block symbol histogram emitted as {count,symbol} groups of four; HIST_SATURATE_EN selects saturating counts
module symbol_histogram_x4 #(
    parameter int DSIZE  = 18,
    parameter int OFFSET = 8
) (
    input logic clk,
    input logic rst,
    symbol_histogram_x4_if.slave bus
);
    localparam int CW    = DSIZE - OFFSET;
    localparam int DEPTH = 2 ** OFFSET;

    typedef enum logic [1:0] {COUNT, SCAN, FLUSH, DRAIN} state_t;

    state_t            state;
    logic [CW-1:0]     cnt [DEPTH];
    logic [OFFSET-1:0] idx;
    logic [DSIZE-1:0]  g [4];
    logic [2:0]        gcnt;

    logic [CW-1:0]     cur;
    logic              nz, full, at_end, accept, stall;
    logic [DSIZE-1:0]  ent;
    logic              tx, tx_last;
    logic [2:0]        tx_n;
    logic [DSIZE-1:0]  tx_g [4];
    logic [4:0]        tx_m;

    assign cur    = cnt[idx];
    assign nz     = cur != '0;
    assign ent    = {cur, idx};
    assign full   = gcnt == 3'd4;
    assign at_end = &idx;
    assign accept = bus.in_valid && bus.in_ready;
    assign stall  = tx && bus.out_valid && !bus.out_ready;
    assign tx_m   = (5'd1 << tx_n) - 5'd1;

    // Decide whether this cycle hands a group to the output register, and what it holds
    always_comb begin
        tx      = 1'b0;
        tx_last = 1'b0;
        tx_n    = gcnt;
        tx_g    = g;
        if (state == SCAN) begin
            if (nz && full) begin
                tx = 1'b1;
            end else if (at_end) begin
                tx      = nz || gcnt != 3'd0;
                tx_last = 1'b1;
                if (nz) begin
                    tx_g[gcnt[1:0]] = ent;
                    tx_n            = gcnt + 3'd1;
                end
            end
        end else if (state == FLUSH) begin
            tx      = 1'b1;
            tx_last = 1'b1;
        end
    end

    // Counting, scan/gather sequencing and the registered output group
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= COUNT;
            for (int i = 0; i < DEPTH; i++) cnt[i] <= '0;
            for (int i = 0; i < 4; i++) g[i] <= '0;
            idx           <= '0;
            gcnt          <= '0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_a0    <= '0;
            bus.out_a1    <= '0;
            bus.out_a2    <= '0;
            bus.out_a3    <= '0;
            bus.out_mask  <= '0;
            bus.out_last  <= 1'b0;
        end else begin
            if (tx && !stall) begin
                bus.out_valid <= 1'b1;
                bus.out_a0    <= tx_n > 3'd0 ? tx_g[0] : '0;
                bus.out_a1    <= tx_n > 3'd1 ? tx_g[1] : '0;
                bus.out_a2    <= tx_n > 3'd2 ? tx_g[2] : '0;
                bus.out_a3    <= tx_n > 3'd3 ? tx_g[3] : '0;
                bus.out_mask  <= tx_m[3:0];
                bus.out_last  <= tx_last;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            case (state)
                COUNT: begin
                    bus.in_ready <= !(accept && bus.in_last);
                    if (accept) begin
`ifdef HIST_SATURATE_EN
                        cnt[bus.in_sym] <= &cnt[bus.in_sym] ? cnt[bus.in_sym] : cnt[bus.in_sym] + CW'(1);
`else
                        cnt[bus.in_sym] <= cnt[bus.in_sym] + CW'(1);
`endif
                        if (bus.in_last) begin
                            state <= SCAN;
                            idx   <= '0;
                            gcnt  <= '0;
                        end
                    end
                end
                SCAN: if (!stall) begin
                    idx <= idx + 1'b1;
                    if (nz) cnt[idx] <= '0;
                    if (nz && full) begin
                        g[0] <= ent;
                        gcnt <= 3'd1;
                    end else if (nz && !at_end) begin
                        g[gcnt[1:0]] <= ent;
                        gcnt         <= gcnt + 3'd1;
                    end else if (at_end) begin
                        gcnt <= '0;
                    end
                    if (at_end) begin
                        state        <= (nz && full) ? FLUSH : (tx ? DRAIN : COUNT);
                        bus.in_ready <= !(nz && full) && !tx;
                    end
                end
                FLUSH: if (!stall) begin
                    state <= DRAIN;
                    gcnt  <= '0;
                end
                default: if (bus.out_valid && bus.out_ready && bus.out_last) begin
                    state        <= COUNT;
                    bus.in_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_symbol_histogram_x4.sv
// tb_symbol_histogram_x4: directed self-checking bench for symbol_histogram_x4
module tb_symbol_histogram_x4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    symbol_histogram_x4_if bus ();
    symbol_histogram_x4 dut (.clk(clk), .rst(rst), .bus(bus));

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] s, input logic l);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_sym   = s;
        bus.in_last  = l;
        while (!bus.in_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) chk("in_ready_timeout", 32'(t), 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int t = 0;
        while (!bus.out_valid && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) chk({tag, "_valid_timeout"}, 32'(t), 32'd0);
    endtask

    task automatic expect_group(input string tag, input logic [17:0] e0, input logic [17:0] e1,
                                input logic [17:0] e2, input logic [17:0] e3,
                                input logic [3:0] m, input logic l);
        wait_valid(tag);
        chk({tag, "_a0"}, 32'(bus.out_a0), 32'(e0));
        chk({tag, "_a1"}, 32'(bus.out_a1), 32'(e1));
        chk({tag, "_a2"}, 32'(bus.out_a2), 32'(e2));
        chk({tag, "_a3"}, 32'(bus.out_a3), 32'(e3));
        chk({tag, "_mask"}, 32'(bus.out_mask), 32'(m));
        chk({tag, "_last"}, 32'(bus.out_last), 32'(l));
        @(negedge clk);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sym    = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_out_a", 32'(bus.out_a0 | bus.out_a1 | bus.out_a2 | bus.out_a3), 32'd0);
            chk("rst_out_mask", 32'(bus.out_mask), 32'd0);
            chk("rst_out_last", 32'(bus.out_last), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        send(8'h41, 1'b0);
        send(8'h41, 1'b0);
        send(8'h42, 1'b0);
        send(8'h10, 1'b1);
        chk("in_ready_after_last", 32'(bus.in_ready), 32'd0);
        expect_group("b1", 18'h00110, 18'h00241, 18'h00142, 18'h0, 4'b0111, 1'b1);

        for (int s = 1; s <= 5; s++) send(8'(s), s == 5);
        expect_group("b2g1", 18'h00101, 18'h00102, 18'h00103, 18'h00104, 4'b1111, 1'b0);
        expect_group("b2g2", 18'h00105, 18'h0, 18'h0, 18'h0, 4'b0001, 1'b1);

        send(8'h00, 1'b0);
        send(8'hFF, 1'b0);
        send(8'h80, 1'b0);
        send(8'h7F, 1'b1);
        expect_group("b3", 18'h00100, 18'h0017F, 18'h00180, 18'h001FF, 4'b1111, 1'b1);
        chk("b3_no_trailing", 32'(bus.out_valid), 32'd0);
        repeat (3) @(negedge clk);
        chk("b3_idle", 32'(bus.out_valid), 32'd0);

        bus.out_ready = 1'b0;
        for (int s = 1; s <= 5; s++) send(8'(s), s == 5);
        wait_valid("bp");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_hold_a0", 32'(bus.out_a0), 32'h00101);
            chk("bp_hold_a3", 32'(bus.out_a3), 32'h00104);
            chk("bp_hold_mask", 32'(bus.out_mask), 32'hF);
            chk("bp_hold_last", 32'(bus.out_last), 32'd0);
        end
        bus.out_ready = 1'b1;
        expect_group("bpg1", 18'h00101, 18'h00102, 18'h00103, 18'h00104, 4'b1111, 1'b0);
        expect_group("bpg2", 18'h00105, 18'h0, 18'h0, 18'h0, 4'b0001, 1'b1);
        send(8'h01, 1'b1);
        expect_group("clr", 18'h00101, 18'h0, 18'h0, 18'h0, 4'b0001, 1'b1);

        for (int i = 0; i < 1100; i++) send(8'h07, i == 1099);
`ifdef HIST_SATURATE_EN
        expect_group("ovf", 18'h3FF07, 18'h0, 18'h0, 18'h0, 4'b0001, 1'b1);
`else
        expect_group("ovf", 18'h04C07, 18'h0, 18'h0, 18'h0, 4'b0001, 1'b1);
`endif

        send(8'h33, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        send(8'h22, 1'b1);
        expect_group("midrst", 18'h00122, 18'h0, 18'h0, 18'h0, 4'b0001, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
